// File: rtl/i2c_wb_sequencer.sv
// Turns one I2C transfer request into the Wishbone command/status sequence of a
// multi-bus I2C controller and reports a single completion response.
module i2c_wb_sequencer #(
    parameter int TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_bus,
    input  logic [6:0] req_addr,
    input  logic       req_rd,
    input  logic [7:0] req_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic [1:0] rsp_status,
    output logic       cyc_o,
    output logic       stb_o,
    output logic       we_o,
    output logic [1:0] adr_o,
    output logic [7:0] dat_o,
    input  logic [7:0] dat_i,
    input  logic       ack_i,
    input  logic       irq_i
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ADR_CSR  = 2'd0;
    localparam logic [1:0] ADR_DPR  = 2'd1;
    localparam logic [1:0] ADR_CMDR = 2'd2;

    localparam logic [2:0] CMD_WRITE    = 3'b001;
    localparam logic [2:0] CMD_READ_NAK = 3'b011;
    localparam logic [2:0] CMD_START    = 3'b100;
    localparam logic [2:0] CMD_STOP     = 3'b101;
    localparam logic [2:0] CMD_SET_BUS  = 3'b110;

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_NAK = 2'b01;
    localparam logic [1:0] ST_AL  = 2'b10;
    localparam logic [1:0] ST_ERR = 2'b11;

    typedef enum logic [2:0] {
        INIT, IDLE, WB_ACC, WAIT_IRQ, RD_CMDR, RESP
    } state_t;

    state_t           state, state_nx;
    logic [2:0]       step, step_nx;
    logic             wb_act;
    logic             acc_done;
    logic             in_acc_nx;
    logic             step_is_cmd;
    logic [CNT_W-1:0] wait_cnt;
    logic             st_set;
    logic [1:0]       st_val;
    logic [1:0]       status_q;
    logic [3:0]       bus_q;
    logic [6:0]       addr_q;
    logic             rd_q;
    logic [7:0]       data_q;
    logic [7:0]       rd_data_q;

    // wb_act is low for the first cycle after every ack, giving the idle gap
    // between consecutive accesses.
    assign acc_done  = wb_act & ack_i;
    assign in_acc_nx = (state_nx == INIT) || (state_nx == WB_ACC) || (state_nx == RD_CMDR);

    // Steps 0/3 and the write-data DPR load/read-data DPR fetch are plain transfers.
    always_comb begin
        step_is_cmd = 1'b1;
        case (step)
            3'd0, 3'd3: step_is_cmd = 1'b0;
            3'd5:       step_is_cmd = rd_q;
            3'd6:       step_is_cmd = !rd_q;
            default:    step_is_cmd = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= INIT;
            step     <= 3'd0;
            wb_act   <= 1'b0;
            wait_cnt <= '0;
        end else begin
            state    <= state_nx;
            step     <= step_nx;
            wb_act   <= in_acc_nx && !acc_done;
            wait_cnt <= (state == WAIT_IRQ) ? wait_cnt + CNT_W'(1) : '0;
        end
    end

    always_comb begin
        state_nx = state;
        step_nx  = step;
        st_set   = 1'b0;
        st_val   = ST_OK;
        case (state)
            INIT:    if (acc_done) state_nx = IDLE;
            IDLE: begin
                if (req_valid) begin
                    state_nx = WB_ACC;
                    step_nx  = 3'd0;
                end
            end
            WB_ACC: begin
                if (acc_done) begin
                    if (step_is_cmd) state_nx = WAIT_IRQ;
                    else             step_nx  = step + 3'd1;
                end
            end
            WAIT_IRQ: begin
                if (irq_i) begin
                    state_nx = RD_CMDR;
                end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_nx = RESP;
                    st_set   = 1'b1;
                    st_val   = ST_ERR;
                end
            end
            RD_CMDR: begin
                if (acc_done) begin
                    if (dat_i[4]) begin
                        state_nx = RESP;
                        st_set   = 1'b1;
                        st_val   = ST_ERR;
                    end else if (dat_i[5]) begin
                        state_nx = RESP;
                        st_set   = 1'b1;
                        st_val   = ST_AL;
                    end else if (dat_i[6]) begin
                        st_set = 1'b1;
                        // A NAK on Set-Bus, Start or Stop means the controller misbehaved.
                        if (step == 3'd1 || step == 3'd2 || step == 3'd7) begin
                            state_nx = RESP;
                            st_val   = ST_ERR;
                        end else begin
                            state_nx = WB_ACC;
                            step_nx  = 3'd7;
                            st_val   = ST_NAK;
                        end
                    end else if (dat_i[7]) begin
                        if (step == 3'd7) begin
                            state_nx = RESP;
                        end else begin
                            state_nx = WB_ACC;
                            step_nx  = step + 3'd1;
                        end
                    end else begin
                        state_nx = RESP;
                        st_set   = 1'b1;
                        st_val   = ST_ERR;
                    end
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = INIT;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
        cyc_o     = wb_act;
        stb_o     = wb_act;
        we_o      = 1'b0;
        adr_o     = 2'd0;
        dat_o     = 8'h00;
        if (wb_act) begin
            case (state)
                INIT: begin
                    we_o  = 1'b1;
                    adr_o = ADR_CSR;
                    dat_o = 8'hC0;
                end
                RD_CMDR: adr_o = ADR_CMDR;
                WB_ACC: begin
                    we_o  = 1'b1;
                    adr_o = ADR_CMDR;
                    case (step)
                        3'd0: begin adr_o = ADR_DPR; dat_o = {4'h0, bus_q}; end
                        3'd1: dat_o = {5'd0, CMD_SET_BUS};
                        3'd2: dat_o = {5'd0, CMD_START};
                        3'd3: begin adr_o = ADR_DPR; dat_o = {addr_q, rd_q}; end
                        3'd4: dat_o = {5'd0, CMD_WRITE};
                        3'd5: begin
                            if (rd_q) dat_o = {5'd0, CMD_READ_NAK};
                            else begin adr_o = ADR_DPR; dat_o = data_q; end
                        end
                        3'd6: begin
                            if (rd_q) begin adr_o = ADR_DPR; we_o = 1'b0; end
                            else dat_o = {5'd0, CMD_WRITE};
                        end
                        default: dat_o = {5'd0, CMD_STOP};
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status_q   <= ST_OK;
            rsp_data   <= 8'h00;
            rsp_status <= ST_OK;
        end else begin
            if (state == IDLE && req_valid) status_q <= ST_OK;
            else if (st_set)                status_q <= st_val;
            if (state_nx == RESP && state != RESP) begin
                rsp_status <= st_set ? st_val : status_q;
                rsp_data   <= rd_data_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid) begin
            bus_q     <= req_bus;
            addr_q    <= req_addr;
            rd_q      <= req_rd;
            data_q    <= req_data;
            rd_data_q <= 8'h00;
        end else if (state == WB_ACC && step == 3'd6 && rd_q && acc_done) begin
            rd_data_q <= dat_i;
        end
    end

endmodule

// File: tb/tb_i2c_wb_sequencer.sv
// Bench for i2c_wb_sequencer: a Wishbone/I2C-controller model plus scoreboards
// of expected bus accesses and expected responses.
module tb_i2c_wb_sequencer;
    localparam int TIMEOUT = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [3:0] req_bus = 4'h0;
    logic [6:0] req_addr = 7'h00;
    logic       req_rd = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic [1:0] rsp_status;
    logic       cyc_o, stb_o, we_o;
    logic [1:0] adr_o;
    logic [7:0] dat_o;
    logic [7:0] dat_i = 8'h00;
    logic       ack_i = 1'b0;
    logic       irq_i = 1'b0;

    int total = 0;
    int bad = 0;
    int cyc_cnt = 0;
    int last_cmd_cyc = 0;
    int irq_left = -1;
    int irq_cd = 0;
    bit ack_hold = 1'b0;
    logic [7:0]  dpr_val = 8'h00;
    logic [10:0] exp_q[$];
    logic [9:0]  rsp_q[$];
    logic [7:0]  cmdr_q[$];
    logic [10:0] mon_a, mon_e;

    i2c_wb_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_bus(req_bus), .req_addr(req_addr), .req_rd(req_rd), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_status(rsp_status),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
        .dat_i(dat_i), .ack_i(ack_i), .irq_i(irq_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic logic [10:0] acc(input logic we, input logic [1:0] adr, input logic [7:0] dat);
        return {we, adr, dat};
    endfunction

    // Reference access sequence for a request that completes without errors.
    function automatic void push_ok_seq(input logic [3:0] bus, input logic [6:0] addr,
                                        input logic rd, input logic [7:0] data);
        exp_q.push_back(acc(1'b1, 2'd1, {4'h0, bus}));
        exp_q.push_back(acc(1'b1, 2'd2, 8'h06));
        exp_q.push_back(acc(1'b0, 2'd2, 8'h00));
        exp_q.push_back(acc(1'b1, 2'd2, 8'h04));
        exp_q.push_back(acc(1'b0, 2'd2, 8'h00));
        exp_q.push_back(acc(1'b1, 2'd1, {addr, rd}));
        exp_q.push_back(acc(1'b1, 2'd2, 8'h01));
        exp_q.push_back(acc(1'b0, 2'd2, 8'h00));
        if (rd) begin
            exp_q.push_back(acc(1'b1, 2'd2, 8'h03));
            exp_q.push_back(acc(1'b0, 2'd2, 8'h00));
            exp_q.push_back(acc(1'b0, 2'd1, 8'h00));
        end else begin
            exp_q.push_back(acc(1'b1, 2'd1, data));
            exp_q.push_back(acc(1'b1, 2'd2, 8'h01));
            exp_q.push_back(acc(1'b0, 2'd2, 8'h00));
        end
        exp_q.push_back(acc(1'b1, 2'd2, 8'h05));
        exp_q.push_back(acc(1'b0, 2'd2, 8'h00));
    endfunction

    // Slave model: acks one cycle after strobe, raises irq a few cycles after each
    // command, returns queued CMDR status bytes and checks every access in order.
    initial begin : wb_model
        forever begin
            @(negedge clk);
            if (!rst) begin
                ack_i  = 1'b0;
                irq_i  = 1'b0;
                irq_cd = 0;
            end else begin
                if (ack_i) begin
                    ack_i = 1'b0;
                end else if (cyc_o && stb_o && !ack_hold) begin
                    ack_i = 1'b1;
                    mon_a = {we_o, adr_o, we_o ? dat_o : 8'h00};
                    if (exp_q.size() > 0) mon_e = exp_q.pop_front();
                    else                  mon_e = 11'h7ff;
                    total++;
                    if (mon_a !== mon_e) begin
                        bad++;
                        $display("FAIL wb_access got we/adr/dat=%h expected=%h", mon_a, mon_e);
                    end
                    if (we_o && adr_o == 2'd2) begin
                        last_cmd_cyc = cyc_cnt;
                        if (irq_left != 0) begin
                            irq_cd = 3;
                            if (irq_left > 0) irq_left--;
                        end
                    end else if (!we_o && adr_o == 2'd2) begin
                        if (cmdr_q.size() > 0) dat_i = cmdr_q.pop_front();
                        else                   dat_i = 8'h80;
                        irq_i = 1'b0;
                    end else if (!we_o) begin
                        dat_i = dpr_val;
                    end
                end
                if (irq_cd > 0) begin
                    irq_cd--;
                    if (irq_cd == 0) irq_i = 1'b1;
                end
            end
        end
    end

    task automatic send_req(input logic [3:0] bus, input logic [6:0] addr,
                            input logic rd, input logic [7:0] data);
        for (int i = 0; i < 50; i++) begin
            if (req_ready === 1'b1) break;
            @(negedge clk);
        end
        req_bus = bus; req_addr = addr; req_rd = rd; req_data = data;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        req_bus  = 4'($urandom);
        req_addr = 7'($urandom);
        req_rd   = 1'($urandom);
        req_data = 8'($urandom);
    endtask

    task automatic wait_rsp(output bit got);
        got = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({cyc_o, stb_o, we_o, adr_o, dat_o, req_ready, rsp_valid, rsp_data, rsp_status} !== 25'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h required=0",
                     {cyc_o, stb_o, we_o, adr_o, dat_o, req_ready, rsp_valid, rsp_data, rsp_status});
        end
        exp_q.push_back(acc(1'b1, 2'd0, 8'hC0));
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b0) begin bad++; $display("FAIL ready_during_init got=%b required=0", req_ready); end
        for (int i = 0; i < 20; i++) begin
            if (req_ready === 1'b1) break;
            @(negedge clk);
        end
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL ready_after_init got=%b required=1", req_ready); end
        total++;
        if (exp_q.size() !== 0) begin bad++; $display("FAIL csr_enable_write pending=%0d required=0", exp_q.size()); end
    endtask

    task automatic test_write();
        bit got;
        logic [9:0] r;
        push_ok_seq(4'h5, 7'h22, 1'b0, 8'h78);
        rsp_q.push_back({2'b00, 8'h00});
        send_req(4'h5, 7'h22, 1'b0, 8'h78);
        wait_rsp(got);
        r = rsp_q.pop_front();
        total++;
        if (!got) begin bad++; $display("FAIL write_rsp got=none required=pulse"); end
        total++;
        if (rsp_status !== r[9:8]) begin bad++; $display("FAIL write_status got=%b required=%b", rsp_status, r[9:8]); end
        @(negedge clk);
        total++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            bad++; $display("FAIL write_rsp_pulse got valid/ready=%b required=01", {rsp_valid, req_ready});
        end
        total++;
        if (exp_q.size() !== 0) begin bad++; $display("FAIL write_sequence pending=%0d required=0", exp_q.size()); end
    endtask

    task automatic test_read();
        bit got;
        logic [9:0] r;
        dpr_val = 8'hA5;
        push_ok_seq(4'h2, 7'h50, 1'b1, 8'h00);
        rsp_q.push_back({2'b00, 8'hA5});
        send_req(4'h2, 7'h50, 1'b1, 8'h00);
        wait_rsp(got);
        r = rsp_q.pop_front();
        total++;
        if (!got) begin bad++; $display("FAIL read_rsp got=none required=pulse"); end
        total++;
        if ({rsp_status, rsp_data} !== r) begin bad++; $display("FAIL read_result got=%h required=%h", {rsp_status, rsp_data}, r); end
        repeat (5) @(negedge clk);
        total++;
        if ({rsp_status, rsp_data} !== r) begin bad++; $display("FAIL read_hold got=%h required=%h", {rsp_status, rsp_data}, r); end
        total++;
        if (exp_q.size() !== 0) begin bad++; $display("FAIL read_sequence pending=%0d required=0", exp_q.size()); end
    endtask

    task automatic test_nak();
        bit got;
        logic [9:0] r;
        cmdr_q.delete();
        cmdr_q.push_back(8'h80); cmdr_q.push_back(8'h80);
        cmdr_q.push_back(8'h40); cmdr_q.push_back(8'h80);
        exp_q.push_back(acc(1'b1, 2'd1, 8'h01));
        exp_q.push_back(acc(1'b1, 2'd2, 8'h06));
        exp_q.push_back(acc(1'b0, 2'd2, 8'h00));
        exp_q.push_back(acc(1'b1, 2'd2, 8'h04));
        exp_q.push_back(acc(1'b0, 2'd2, 8'h00));
        exp_q.push_back(acc(1'b1, 2'd1, 8'h20));
        exp_q.push_back(acc(1'b1, 2'd2, 8'h01));
        exp_q.push_back(acc(1'b0, 2'd2, 8'h00));
        exp_q.push_back(acc(1'b1, 2'd2, 8'h05));
        exp_q.push_back(acc(1'b0, 2'd2, 8'h00));
        rsp_q.push_back({2'b01, 8'h00});
        send_req(4'h1, 7'h10, 1'b0, 8'h33);
        wait_rsp(got);
        r = rsp_q.pop_front();
        total++;
        if (!got) begin bad++; $display("FAIL nak_rsp got=none required=pulse"); end
        total++;
        if ({rsp_status, rsp_data} !== r) begin bad++; $display("FAIL nak_result got=%h required=%h", {rsp_status, rsp_data}, r); end
        repeat (2) @(negedge clk);
        total++;
        if (exp_q.size() !== 0) begin bad++; $display("FAIL nak_sequence pending=%0d required=0", exp_q.size()); end
    endtask

    task automatic test_timeout();
        bit got;
        int lat;
        logic [9:0] r;
        irq_left = 1;
        exp_q.push_back(acc(1'b1, 2'd1, 8'h06));
        exp_q.push_back(acc(1'b1, 2'd2, 8'h06));
        exp_q.push_back(acc(1'b0, 2'd2, 8'h00));
        exp_q.push_back(acc(1'b1, 2'd2, 8'h04));
        rsp_q.push_back({2'b11, 8'h00});
        send_req(4'h6, 7'h7F, 1'b0, 8'h5A);
        wait_rsp(got);
        lat = cyc_cnt - last_cmd_cyc - 1;
        r = rsp_q.pop_front();
        total++;
        if (!got) begin bad++; $display("FAIL timeout_rsp got=none required=pulse"); end
        total++;
        if (rsp_status !== r[9:8]) begin bad++; $display("FAIL timeout_status got=%b required=%b", rsp_status, r[9:8]); end
        total++;
        if (lat !== TIMEOUT) begin bad++; $display("FAIL timeout_latency got=%0d required=%0d", lat, TIMEOUT); end
        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() !== 0) begin bad++; $display("FAIL timeout_sequence pending=%0d required=0", exp_q.size()); end
        irq_left = -1;
    endtask

    task automatic test_abort();
        bit got;
        logic [9:0] r;
        for (int k = 0; k < 3; k++) begin
            cmdr_q.delete();
            exp_q.push_back(acc(1'b1, 2'd1, 8'h03));
            exp_q.push_back(acc(1'b1, 2'd2, 8'h06));
            exp_q.push_back(acc(1'b0, 2'd2, 8'h00));
            case (k)
                0: begin
                    cmdr_q.push_back(8'h80); cmdr_q.push_back(8'h20);
                    exp_q.push_back(acc(1'b1, 2'd2, 8'h04));
                    exp_q.push_back(acc(1'b0, 2'd2, 8'h00));
                    rsp_q.push_back({2'b10, 8'h00});
                end
                1: begin
                    cmdr_q.push_back(8'h80); cmdr_q.push_back(8'h40);
                    exp_q.push_back(acc(1'b1, 2'd2, 8'h04));
                    exp_q.push_back(acc(1'b0, 2'd2, 8'h00));
                    rsp_q.push_back({2'b11, 8'h00});
                end
                default: begin
                    cmdr_q.push_back(8'h90);
                    rsp_q.push_back({2'b11, 8'h00});
                end
            endcase
            send_req(4'h3, 7'h11, 1'b0, 8'h00);
            wait_rsp(got);
            r = rsp_q.pop_front();
            total++;
            if (!got) begin bad++; $display("FAIL abort%0d_rsp got=none required=pulse", k); end
            total++;
            if (rsp_status !== r[9:8]) begin bad++; $display("FAIL abort%0d_status got=%b required=%b", k, rsp_status, r[9:8]); end
            repeat (3) @(negedge clk);
            total++;
            if (exp_q.size() !== 0) begin bad++; $display("FAIL abort%0d_sequence pending=%0d required=0", k, exp_q.size()); end
        end
    endtask

    task automatic test_back_to_back();
        bit got;
        logic [9:0] r;
        dpr_val = 8'h5C;
        push_ok_seq(4'h4, 7'h2A, 1'b0, 8'h11);
        push_ok_seq(4'h9, 7'h3C, 1'b1, 8'h00);
        rsp_q.push_back({2'b00, 8'h00});
        rsp_q.push_back({2'b00, 8'h5C});
        send_req(4'h4, 7'h2A, 1'b0, 8'h11);
        wait_rsp(got);
        r = rsp_q.pop_front();
        total++;
        if (!got) begin bad++; $display("FAIL b2b_first_rsp got=none required=pulse"); end
        total++;
        if (rsp_status !== r[9:8]) begin bad++; $display("FAIL b2b_first_status got=%b required=%b", rsp_status, r[9:8]); end
        req_bus = 4'h9; req_addr = 7'h3C; req_rd = 1'b1; req_data = 8'h00;
        req_valid = 1'b1;
        @(negedge clk);
        total++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            bad++; $display("FAIL b2b_ready got valid/ready=%b required=01", {rsp_valid, req_ready});
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_bus = 4'hF; req_addr = 7'h7F; req_rd = 1'b0; req_data = 8'hFF;
        total++;
        if (cyc_o !== 1'b1) begin bad++; $display("FAIL b2b_zero_gap got cyc_o=%b required=1", cyc_o); end
        wait_rsp(got);
        r = rsp_q.pop_front();
        total++;
        if (!got) begin bad++; $display("FAIL b2b_second_rsp got=none required=pulse"); end
        total++;
        if ({rsp_status, rsp_data} !== r) begin bad++; $display("FAIL b2b_second_result got=%h required=%h", {rsp_status, rsp_data}, r); end
        total++;
        if (exp_q.size() !== 0) begin bad++; $display("FAIL b2b_sequence pending=%0d required=0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        bit seen_cyc;
        bit seen_rsp;
        ack_hold = 1'b1;
        seen_cyc = 1'b0;
        seen_rsp = 1'b0;
        send_req(4'h1, 7'h12, 1'b0, 8'h34);
        for (int i = 0; i < 10; i++) begin
            if (cyc_o === 1'b1) begin seen_cyc = 1'b1; break; end
            @(negedge clk);
        end
        total++;
        if (!seen_cyc) begin bad++; $display("FAIL midreset_access got cyc_o=0 required=1"); end
        #2 rst = 1'b0;
        #1;
        total++;
        if ({cyc_o, stb_o} !== 2'b00) begin bad++; $display("FAIL midreset_drop got cyc/stb=%b required=00", {cyc_o, stb_o}); end
        @(negedge clk);
        ack_hold = 1'b0;
        exp_q.push_back(acc(1'b1, 2'd0, 8'hC0));
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) seen_rsp = 1'b1;
            if (req_ready === 1'b1) break;
        end
        total++;
        if (seen_rsp) begin bad++; $display("FAIL midreset_no_rsp got rsp_valid=1 required=0"); end
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL midreset_ready got=%b required=1", req_ready); end
        total++;
        if (exp_q.size() !== 0) begin bad++; $display("FAIL midreset_csr_rewrite pending=%0d required=0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_nak();
        test_timeout();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
